// File: rtl/debug_bridge_uart_pkg.sv
// debug_bridge_pkg: shared state encodings and framing constants for the
// UART debug bridge and its byte receiver.
package debug_bridge_pkg;

  localparam int UART_BYTES_PER_WORD = 4;
  localparam int UART_FRAME_BITS     = 10;
  localparam int RXFIFO_DEPTH        = 4;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {H_IDLE, H_ACK, H_HOLD} hs_state_t;

endpackage

// File: rtl/debug_bridge_uart_if.sv
// debug_bridge_uart_if: debug word handshake (req/wr/ack with d/q words).
// The master is the user-side initiator; the slave is the bridge.
interface debug_bridge_uart_if;
  logic        req;
  logic        wr;
  logic        ack;
  logic [31:0] d;
  logic [31:0] q;

  modport master (output req, output wr, output d, input ack, input q);
  modport slave  (input req, input wr, input d, output ack, output q);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte receiver. Synchronises rxd, times bits from the
// start-bit falling edge, and flags bytes whose stop bit samples low.
module uart_byte_rx
  import debug_bridge_pkg::*;
#(
  parameter int clks_per_bit = 868
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       frame_err_stb,
  output logic       busy
);
  localparam int CNT_W = $clog2(clks_per_bit);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clks_per_bit - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(clks_per_bit / 2 - 1);

  rx_state_t        state, state_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sh;
  logic             tick, half_tick;

  assign tick      = (cnt == BIT_LAST);
  assign half_tick = (cnt == HALF_LAST);
  assign busy      = (state != RX_IDLE);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) state <= RX_IDLE;
    else           state <= state_next;
  end

  // Next state: start bit is re-checked at mid-bit to reject glitches
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_next = RX_START;
      RX_START: if (half_tick) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (tick) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Bit timer, bit index and result strobes
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      cnt           <= '0;
      bit_idx       <= '0;
      byte_stb      <= 1'b0;
      frame_err_stb <= 1'b0;
    end else begin
      byte_stb      <= 1'b0;
      frame_err_stb <= 1'b0;
      if (state == RX_IDLE || (state == RX_START && half_tick) || tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == RX_START && half_tick) bit_idx <= '0;
      if (state == RX_DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (state == RX_STOP && tick) begin
        if (rx_sync) byte_stb      <= 1'b1;
        else         frame_err_stb <= 1'b1;
      end
    end
  end

  // Data shift register (LSB arrives first) and completed byte
  always_ff @(posedge clk) begin
    if (state == RX_DATA && tick) sh <= {rx_sync, sh[7:1]};
    if (state == RX_STOP && tick && rx_sync) rx_byte <= sh;
  end

endmodule

// File: rtl/debug_bridge_uart.sv
// debug_bridge_uart: UART transport for the debug req/wr/ack word interface.
// Words travel as 4 bytes, most-significant byte first, 8N1.
// Build option: DEBUG_BRIDGE_UART_RXFIFO_EN replaces the single RX holding
// register with a 4-entry RX word FIFO.
module debug_bridge_uart
  import debug_bridge_pkg::*;
#(
  parameter int clks_per_bit = 868,
  parameter int timeout_bits = 20
) (
  input  logic clk,
  input  logic reset_in,
  input  logic rxd,
  output logic txd,
  debug_bridge_uart_if.slave bus,
  output logic overflow,
  output logic framing_err
);
  localparam int CNT_W = $clog2(clks_per_bit);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(clks_per_bit - 1);
  localparam int TMO_CYCLES = timeout_bits * clks_per_bit;
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [1:0] LAST_BYTE = 2'(UART_BYTES_PER_WORD - 1);

  logic [7:0]       rx_byte;
  logic             byte_stb, frame_err_stb, rx_busy;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_hi;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expire;
  logic             word_stb, push, pop, word_avail, word_drop;
  logic [31:0]      word_new, head_word;
  hs_state_t        h_state, h_next;
  logic             accept, is_write, tx_load;
  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic             tx_tick;
  logic [2:0]       tx_bit;
  logic [1:0]       tx_idx;
  logic [31:0]      tx_word;
  logic [7:0]       tx_sh;

  uart_byte_rx #(.clks_per_bit(clks_per_bit)) u_rx (
    .clk           (clk),
    .reset_in      (reset_in),
    .rxd           (rxd),
    .rx_byte       (rx_byte),
    .byte_stb      (byte_stb),
    .frame_err_stb (frame_err_stb),
    .busy          (rx_busy)
  );

  assign word_stb   = byte_stb && (byte_cnt == LAST_BYTE);
  assign word_new   = {asm_hi, rx_byte};
  assign tmo_expire = (byte_cnt != 2'd0) && !rx_busy && (tmo_cnt == TMO_LAST);

  // Byte counter, inter-byte timeout and sticky framing flag
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      framing_err <= 1'b0;
    end else begin
      if (frame_err_stb) begin
        byte_cnt    <= '0;
        framing_err <= 1'b1;
      end else if (byte_stb) begin
        byte_cnt <= byte_cnt + 2'd1;
      end else if (tmo_expire) begin
        byte_cnt <= '0;
      end
      if (byte_cnt == 2'd0 || rx_busy || byte_stb || tmo_expire) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Upper three bytes of the word being assembled, MSB byte first
  always_ff @(posedge clk) begin
    if (byte_stb) asm_hi <= {asm_hi[15:0], rx_byte};
  end

`ifdef DEBUG_BRIDGE_UART_RXFIFO_EN
  localparam int PTR_W = $clog2(RXFIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(RXFIFO_DEPTH);

  logic [31:0]       fifo_mem [RXFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;

  assign word_avail = (fifo_cnt != '0);
  assign head_word  = fifo_mem[rd_ptr];
  // A pop on the same cycle frees the slot, so push-at-full is allowed then
  assign push       = word_stb && ((fifo_cnt != FIFO_FULL) || pop);

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= word_new;
  end
`else
  logic        word_valid;
  logic [31:0] hold_word;

  assign word_avail = word_valid;
  assign head_word  = hold_word;
  // A read taking the old word on this cycle makes room for the new one
  assign push       = word_stb && (!word_valid || pop);

  // Holding-register valid flag
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in)  word_valid <= 1'b0;
    else if (push)  word_valid <= 1'b1;
    else if (pop)   word_valid <= 1'b0;
  end

  // Holding register
  always_ff @(posedge clk) begin
    if (push) hold_word <= word_new;
  end
`endif

  assign word_drop = word_stb && !push;

  // Sticky overflow: a complete word found no room
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in)      overflow <= 1'b0;
    else if (word_drop) overflow <= 1'b1;
  end

  // Handshake state register, transfer direction and read data
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      h_state  <= H_IDLE;
      is_write <= 1'b0;
      bus.q    <= '0;
    end else begin
      h_state <= h_next;
      if (accept) is_write <= bus.wr;
      if (pop)    bus.q    <= head_word;
    end
  end

  // Handshake next state: req/wr only looked at in H_IDLE
  always_comb begin
    h_next = h_state;
    accept = 1'b0;
    case (h_state)
      H_IDLE: begin
        if (bus.req && (bus.wr ? (tx_state == TX_IDLE) : word_avail)) begin
          accept = 1'b1;
          h_next = H_ACK;
        end
      end
      H_ACK:   h_next = H_HOLD;
      H_HOLD:  h_next = H_IDLE;
      default: h_next = H_IDLE;
    endcase
  end

  assign pop     = accept && !bus.wr;
  assign bus.ack = (h_state == H_ACK);
  assign tx_load = (h_state == H_ACK) && is_write;
  assign tx_tick = (tx_cnt == BIT_LAST);

  // TX state register
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) tx_state <= TX_IDLE;
    else           tx_state <= tx_next;
  end

  // TX next state: 10 bit-times per byte, byte index walks 3 down to 0
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = (tx_idx == 2'd0) ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX bit timer, bit counter and byte index
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_idx <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 1'b1;
      if (tx_load) tx_idx <= LAST_BYTE;
      if (tx_state == TX_START && tx_tick) tx_bit <= '0;
      if (tx_state == TX_DATA && tx_tick)  tx_bit <= tx_bit + 3'd1;
      if (tx_state == TX_STOP && tx_tick)  tx_idx <= tx_idx - 2'd1;
    end
  end

  // TX word capture and per-byte shift register
  always_ff @(posedge clk) begin
    if (tx_load) tx_word <= bus.d;
    if (tx_state == TX_START && tx_tick) tx_sh <= tx_word[{tx_idx, 3'b000} +: 8];
    else if (tx_state == TX_DATA && tx_tick) tx_sh <= {1'b0, tx_sh[7:1]};
  end

  assign txd = (tx_state == TX_START) ? 1'b0 :
               (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;

endmodule

// File: doc/debug_bridge_uart.md
Name: debug_bridge_uart

Overview:
- UART transport for the debug req/wr/ack word interface, for boards with no virtual-JTAG access.
- Responds to a user-side initiator: reads return host→FPGA words on q; writes send d to the host.
- Serialises 32-bit words as 4 bytes, most-significant byte first, 8N1, LSB-first bits.
- Drop-in alternative to the JTAG bridge beneath demo/debug top levels.

Parameters:
- clks_per_bit, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- timeout_bits, 20, idle bit-times after which a partial RX word is discarded.

Ports:
- clk  in  1  system clock
- reset_in  in  1  asynchronous active-low reset
- rxd  in  1  serial from host, asynchronous
- txd  out  1  serial to host, idles high
- d  in  32  word to send; sampled on the ack cycle of a write
- q  out  32  last received word; valid on the ack cycle of a read and held until the next read ack
- req  in  1  transaction request, level
- wr  in  1  1 = write (to host), 0 = read (from host); qualified by req
- ack  out  1  single-cycle completion pulse
- overflow  out  1  sticky: a complete RX word was dropped
- framing_err  out  1  sticky: a stop bit sampled low

Behaviour:
- Reset: reset_in is asynchronous, active-low; clock is clk.
  - Reset values: txd=1, ack=0, q=0, overflow=0, framing_err=0.
  - RX/TX engines return to idle and the byte counter clears.
  - Reset mid-byte aborts the byte; no partial word is ever presented.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - Falling edge in RX_IDLE → RX_START; start bit sampled at clks_per_bit/2 and must be 0, otherwise return to RX_IDLE.
  - RX_DATA: 8 samples, each one clks_per_bit apart.
  - RX_STOP: stop bit must be 1. If it is 0: set framing_err, discard the byte, clear the byte counter.
  - Good bytes shift into a 32-bit assembler, MSB byte first. The 4th byte raises word_valid and loads the holding register.
  - If word_valid is already set when a new word completes: the new word is dropped and overflow is set.
  - Inter-byte timeout: a partial word (byte count 1..3) idle for timeout_bits×clks_per_bit cycles clears the byte count.
- TX path:
  - States TX_IDLE, TX_START, TX_DATA, TX_STOP. A 2-bit byte index walks 3→0; the shift register is loaded from d.
  - Each byte is 1 start + 8 data + 1 stop = 10 bit-times, so a word takes 40×clks_per_bit cycles.
- Handshake FSM, states H_IDLE, H_ACK, H_HOLD:
  - H_IDLE with req=1, wr=1: wait for TX_IDLE, then latch d into TX, pulse ack, go to H_ACK. Ack is on acceptance, not on completion.
  - H_IDLE with req=1, wr=0: wait for word_valid, then load q, clear word_valid, pulse ack.
  - H_ACK → H_HOLD → H_IDLE. req is ignored for the cycle after ack, because initiators drive req<=!ack.
  - req dropping before ack cancels the wait with no side effect.
  - wr is sampled only in H_IDLE; a change while waiting switches the waited-for condition with no side effect.
- Simultaneous events:
  - RX word completing on the same cycle as a read ack: the read takes the old word, the new word becomes valid, no overflow.
  - TX and RX run fully duplex.
- Minimum ack spacing is 3 cycles.

Optional Feature:
- Macro: DEBUG_BRIDGE_UART_RXFIFO_EN.
- Defined: a 4-entry RX word FIFO replaces the holding register.
  - Read waits for non-empty and pops on ack.
  - A push when full drops the word and sets overflow.
  - Simultaneous push and pop at full is allowed with no overflow.
- Undefined: single holding register as described in Behaviour.

Decomposition:
- Shared package debug_bridge_pkg:
  - state enums for RX, TX and handshake
  - UART_BYTES_PER_WORD=4, UART_FRAME_BITS=10
  - RXFIFO_DEPTH=4
- One natural sub-module, uart_byte_rx: synchroniser, bit timing, framing check. It outputs byte, byte_stb and frame_err_stb.
- TX and word assembly stay in the top module.

Test Plan:
- Bench setting clks_per_bit=4 applies to all scenarios.
- Host sends 0x12,0x34,0x56,0x78 then the initiator reads → ack once, q=0x12345678, overflow=0.
- Write d=0xDEADBEEF → ack within 2 cycles; txd carries 0xDE,0xAD,0xBE,0xEF over 160 cycles; a second write is not acked until TX_IDLE.
- Two full words with no read (feature off) → the first is read back, overflow=1. With feature on, 5 words → 4 read back in order, overflow=1.
- Host sends 0x11,0x22, idles 100 cycles, then 0xAA,0xBB,0xCC,0xDD → read returns 0xAABBCCDD.
- Byte with stop bit low → framing_err=1; the following 4 good bytes are still assembled correctly.
- Reset asserted mid-TX byte → txd=1 immediately; pending read not acked; the next write after reset transmits a clean frame.
